mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares one word-wide memory port among `N_REQ` compute engines (matrix multiplication and similar accelerators) speaking the codebase's memory protocol: `mem_operation` 01 read, 11 write, 00 none; one transaction completes per `mem_opdone` pulse. It sits between the engines and the memory controller. It grants one requester per transaction, registers the granted request onto the shared port, and routes the completion pulse back only to the winner. A timeout watchdog prevents a stuck transaction from locking the port.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `DATA_W`, 32, data word width (set to `` `TYPE_BW``)
- `TIMEOUT`, 1024, maximum cycles in GRANT before forced release (≥2)
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `req_operation_i`  in  2*N_REQ  per-requester `mem_operation`; requester r occupies bits [2r+1:2r]
- `req_addr_i`  in  32*N_REQ  per-requester address, packed the same way
- `req_data_i`  in  DATA_W*N_REQ  per-requester write data
- `req_opdone_o`  out  N_REQ  per-requester completion pulse
- `req_data_o`  out  DATA_W  read data broadcast to all requesters; equals `mem_data_i`
- `mem_operation_o`  out  2  registered operation to memory
- `mem_addr_o`  out  32  registered address
- `mem_data_o`  out  DATA_W  registered write data
- `mem_data_i`  in  DATA_W  read data from memory
- `mem_opdone_i`  in  1  memory completion pulse
- `grant_o`  out  N_REQ  one-hot current grant, registered
- `timeout_err_o`  out  1  sticky; set on watchdog release
- `timeout_id_o`  out  3  index of the requester that timed out (last event)

## Operation
- Reset values: all outputs 0. `last` pointer is N_REQ-1, so requester 0 wins first. State IDLE, watchdog counter 0.
- Request pending for r: `req_operation_i[r] != 2'b00`. Value 2'b10 is illegal and is treated as no request.
- IDLE:
  - `mem_operation_o` is 00 and `grant_o` is 0.
  - If any request is pending, pick the first pending index after `last` (circular).
  - Latch that requester's op, addr and data into the `mem_*_o` registers.
  - Set `grant_o` one-hot and go to GRANT.
  - The winner is chosen on the sampling edge.
- GRANT:
  - Outputs hold the latched values. The requester must keep op, addr and data stable until its opdone.
  - `req_opdone_o[g] = mem_opdone_i` when in GRANT, combinationally. All other bits are 0.
  - On `mem_opdone_i`: release. Clear `mem_operation_o`, `grant_o`, `mem_addr_o` and `mem_data_o` to 0. Set `last = g` and go to IDLE.
  - On abort (granted requester's op becomes 00 with no opdone that cycle): release the same way, with no opdone delivered.
  - Watchdog counts cycles spent in GRANT. When the count reaches TIMEOUT-1 with no opdone:
    - release;
    - set `timeout_err_o`;
    - load `timeout_id_o = g`;
    - set `last = g`.
- Simultaneous events:
  - opdone wins over abort and over timeout; the pulse is delivered and no error is flagged.
- Every transaction passes through IDLE for ≥1 cycle. Memory therefore always sees `mem_operation_o` = 00 between transactions, even for back-to-back reads by one requester.
- `timeout_err_o` clears only on reset.
- Reset mid-transaction:
  - outputs drop to 0 immediately (async);
  - no opdone is delivered;
  - the in-flight memory access is abandoned.

## Timing
- Grant latency: request sampled high at edge E, so `mem_operation_o`, `grant_o` and the address are valid after E.
- Completion: `req_opdone_o` pulses in the same cycle as `mem_opdone_i`. Port outputs are 00 after the next edge.
- Minimum port occupancy is 2 cycles per transaction: 1 IDLE plus ≥1 GRANT.
- Fairness: with all N_REQ requesters continuously pending, each is granted exactly once every N_REQ transactions.
- Worst-case wait for a pending requester is (N_REQ-1) transactions, each bounded by TIMEOUT+1 cycles.

## Test plan
- Single requester:
  - stimulus: req 1 reads addr 0x10; memory returns 0xCAFE with opdone 3 cycles after grant.
  - required: `grant_o`=0010 one cycle after the request; `mem_addr_o`=0x10; `req_opdone_o`=0010 for exactly 1 cycle with `req_data_o`=0xCAFE; `mem_operation_o`=00 for ≥1 cycle before the next grant.
- Round-robin:
  - stimulus: all 4 requesters pending continuously; memory acks in 1 cycle.
  - required: grant order 0,1,2,3,0,1; no requester is ever granted twice in a row.
- Write pass-through:
  - stimulus: req 2 writes 0xDEAD to 0x84 while req 0 is waiting.
  - required: `mem_operation_o`=11, `mem_data_o`=0xDEAD; req 0 is granted only after req 2's opdone plus 1 IDLE cycle.
- Timeout:
  - stimulus: TIMEOUT=8; req 3 granted; memory never acks.
  - required: release after 8 GRANT cycles; `timeout_err_o`=1; `timeout_id_o`=3; no opdone pulse; req 0 is served next.
- Abort vs opdone:
  - stimulus: granted req 0 drops op; in a second trial, it drops op in the same cycle as opdone.
  - required: the first trial releases with no pulse; the second delivers the pulse; neither trial sets `timeout_err_o`.
- Async reset mid-GRANT:
  - stimulus: assert `reset` between clock edges.
  - required: all outputs are 0 before the next edge; after release, req 0 wins first.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: per-requester request/completion lanes plus the single memory port.
// The arbiter takes the slave view; requesters and the memory controller together take the master view.
interface mem_port_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [2*N_REQ-1:0]      req_operation_i;
  logic [32*N_REQ-1:0]     req_addr_i;
  logic [DATA_W*N_REQ-1:0] req_data_i;
  logic [N_REQ-1:0]        req_opdone_o;
  logic [DATA_W-1:0]       req_data_o;
  logic [1:0]              mem_operation_o;
  logic [31:0]             mem_addr_o;
  logic [DATA_W-1:0]       mem_data_o;
  logic [DATA_W-1:0]       mem_data_i;
  logic                    mem_opdone_i;
  logic [N_REQ-1:0]        grant_o;
  logic                    timeout_err_o;
  logic [2:0]              timeout_id_o;

  modport slave (
    input  req_operation_i, req_addr_i, req_data_i, mem_data_i, mem_opdone_i,
    output req_opdone_o, req_data_o, mem_operation_o, mem_addr_o, mem_data_o,
           grant_o, timeout_err_o, timeout_id_o
  );

  modport master (
    output req_operation_i, req_addr_i, req_data_i, mem_data_i, mem_opdone_i,
    input  req_opdone_o, req_data_o, mem_operation_o, mem_addr_o, mem_data_o,
           grant_o, timeout_err_o, timeout_id_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port among N_REQ engines,
// with completion routing back to the winner and a watchdog that frees a stuck port.
module mem_port_arbiter #(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);
  localparam int              WD_W    = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t            state_reg;
  logic [2:0]        last_reg;
  logic [2:0]        gidx_reg;
  logic [WD_W-1:0]   wd_reg;
  logic [N_REQ-1:0]  grant_reg;
  logic [1:0]        op_reg;
  logic [31:0]       addr_reg;
  logic [DATA_W-1:0] data_reg;
  logic              timeout_err_reg;
  logic [2:0]        timeout_id_reg;

  // Ops 01 and 11 both have bit 0 set; 00 and the illegal 10 do not.
  logic [N_REQ-1:0] pend;
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_pend
      assign pend[gi] = bus.req_operation_i[2*gi];
    end
  endgenerate

  // First pending index strictly above last wins; otherwise wrap to the lowest pending index.
  logic       hi_found, lo_found, win_found;
  logic [2:0] hi_idx, lo_idx, win_idx;
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (pend[j]) begin
        if (j > int'(last_reg)) begin
          hi_found = 1'b1;
          hi_idx   = 3'(j);
        end else begin
          lo_found = 1'b1;
          lo_idx   = 3'(j);
        end
      end
    end
    win_found = hi_found | lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  logic [1:0] granted_op;
  logic       abort, expired;
  assign granted_op = bus.req_operation_i[2*int'(gidx_reg) +: 2];
  assign abort      = (granted_op == 2'b00);
  assign expired    = (wd_reg == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      last_reg        <= 3'(N_REQ - 1);
      gidx_reg        <= '0;
      wd_reg          <= '0;
      grant_reg       <= '0;
      op_reg          <= '0;
      addr_reg        <= '0;
      data_reg        <= '0;
      timeout_err_reg <= 1'b0;
      timeout_id_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          wd_reg <= '0;
          if (win_found) begin
            state_reg <= GRANT;
            gidx_reg  <= win_idx;
            grant_reg <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
            op_reg    <= bus.req_operation_i[2*int'(win_idx) +: 2];
            addr_reg  <= bus.req_addr_i[32*int'(win_idx) +: 32];
            data_reg  <= bus.req_data_i[DATA_W*int'(win_idx) +: DATA_W];
          end
        end
        GRANT: begin
          wd_reg <= wd_reg + 1'b1;
          if (bus.mem_opdone_i || abort || expired) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            op_reg    <= '0;
            addr_reg  <= '0;
            data_reg  <= '0;
            last_reg  <= gidx_reg;
            // A completion in the expiry cycle is a normal finish, not a timeout.
            if (!bus.mem_opdone_i && expired) begin
              timeout_err_reg <= 1'b1;
              timeout_id_reg  <= gidx_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_opdone_o    = (state_reg == GRANT && bus.mem_opdone_i) ? grant_reg : '0;
  assign bus.req_data_o      = bus.mem_data_i;
  assign bus.mem_operation_o = op_reg;
  assign bus.mem_addr_o      = addr_reg;
  assign bus.mem_data_o      = data_reg;
  assign bus.grant_o         = grant_reg;
  assign bus.timeout_err_o   = timeout_err_reg;
  assign bus.timeout_id_o    = timeout_id_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, round-robin order, write pass-through,
// watchdog release, abort versus completion, and asynchronous reset mid-grant.
module tb_mem_port_arbiter;
  localparam int N_REQ   = 4;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus_if ();

  mem_port_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] data);
    bus_if.req_operation_i[2*r +: 2] = op;
    bus_if.req_addr_i[32*r +: 32]    = addr;
    bus_if.req_data_i[32*r +: 32]    = data;
  endtask

  task automatic do_reset();
    bus_if.req_operation_i = '0;
    bus_if.req_addr_i      = '0;
    bus_if.req_data_i      = '0;
    bus_if.mem_data_i      = '0;
    bus_if.mem_opdone_i    = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int seq [6];
    logic [3:0] exp_g;
    seq = '{0, 1, 2, 3, 0, 1};

    // Reset values
    #1;
    do_reset();
    reset = 1'b1;
    #1;
    check("rst_grant",   64'(bus_if.grant_o), 64'h0);
    check("rst_memop",   64'(bus_if.mem_operation_o), 64'h0);
    check("rst_addr",    64'(bus_if.mem_addr_o), 64'h0);
    check("rst_terr",    64'(bus_if.timeout_err_o), 64'h0);
    check("rst_tid",     64'(bus_if.timeout_id_o), 64'h0);
    check("rst_opdone",  64'(bus_if.req_opdone_o), 64'h0);

    // Single requester read
    do_reset();
    set_req(1, 2'b01, 32'h10, 32'h0);
    tick();
    check("t1_grant",    64'(bus_if.grant_o), 64'h2);
    check("t1_memop",    64'(bus_if.mem_operation_o), 64'h1);
    check("t1_addr",     64'(bus_if.mem_addr_o), 64'h10);
    tick();
    tick();
    tick();
    bus_if.mem_opdone_i = 1'b1;
    bus_if.mem_data_i   = 32'hCAFE;
    #1;
    check("t1_opdone",   64'(bus_if.req_opdone_o), 64'h2);
    check("t1_rdata",    64'(bus_if.req_data_o), 64'hCAFE);
    tick();
    check("t1_opdone_1cyc", 64'(bus_if.req_opdone_o), 64'h0);
    check("t1_idle_op",  64'(bus_if.mem_operation_o), 64'h0);
    check("t1_idle_gnt", 64'(bus_if.grant_o), 64'h0);
    bus_if.mem_opdone_i = 1'b0;
    tick();
    check("t1_regrant",  64'(bus_if.grant_o), 64'h2);
    set_req(1, 2'b00, 32'h0, 32'h0);
    bus_if.mem_opdone_i = 1'b1;
    tick();
    bus_if.mem_opdone_i = 1'b0;
    check("t1_release",  64'(bus_if.grant_o), 64'h0);

    // Round-robin with all requesters pending and 1-cycle acks
    do_reset();
    for (int r = 0; r < N_REQ; r++) set_req(r, 2'b01, 32'(r * 256), 32'h0);
    tick();
    for (int k = 0; k < 6; k++) begin
      exp_g = 4'b0001 << seq[k];
      check($sformatf("rr_grant_%0d", k), 64'(bus_if.grant_o), 64'(exp_g));
      check($sformatf("rr_addr_%0d", k),  64'(bus_if.mem_addr_o), 64'(seq[k] * 256));
      bus_if.mem_opdone_i = 1'b1;
      tick();
      bus_if.mem_opdone_i = 1'b0;
      check($sformatf("rr_idle_%0d", k),  64'(bus_if.grant_o), 64'h0);
      tick();
    end
    for (int r = 0; r < N_REQ; r++) set_req(r, 2'b00, 32'h0, 32'h0);
    tick();
    check("rr_abort_rel", 64'(bus_if.grant_o), 64'h0);

    // Write pass-through while req 0 waits
    do_reset();
    set_req(2, 2'b11, 32'h84, 32'hDEAD);
    tick();
    check("wr_grant",    64'(bus_if.grant_o), 64'h4);
    check("wr_memop",    64'(bus_if.mem_operation_o), 64'h3);
    check("wr_wdata",    64'(bus_if.mem_data_o), 64'hDEAD);
    check("wr_addr",     64'(bus_if.mem_addr_o), 64'h84);
    set_req(0, 2'b01, 32'h20, 32'h0);
    tick();
    check("wr_hold",     64'(bus_if.grant_o), 64'h4);
    bus_if.mem_opdone_i = 1'b1;
    set_req(2, 2'b00, 32'h0, 32'h0);
    #1;
    check("wr_opdone",   64'(bus_if.req_opdone_o), 64'h4);
    tick();
    bus_if.mem_opdone_i = 1'b0;
    check("wr_idle_gnt", 64'(bus_if.grant_o), 64'h0);
    check("wr_idle_op",  64'(bus_if.mem_operation_o), 64'h0);
    tick();
    check("wr_next_gnt", 64'(bus_if.grant_o), 64'h1);
    check("wr_next_addr", 64'(bus_if.mem_addr_o), 64'h20);
    set_req(0, 2'b00, 32'h0, 32'h0);
    tick();

    // Watchdog release
    do_reset();
    set_req(3, 2'b01, 32'h40, 32'h0);
    tick();
    check("to_grant",    64'(bus_if.grant_o), 64'h8);
    set_req(0, 2'b01, 32'h50, 32'h0);
    for (int c = 1; c < TIMEOUT; c++) begin
      tick();
      check($sformatf("to_hold_%0d", c), 64'(bus_if.grant_o), 64'h8);
    end
    check("to_no_opdone", 64'(bus_if.req_opdone_o), 64'h0);
    tick();
    check("to_release",  64'(bus_if.grant_o), 64'h0);
    check("to_err",      64'(bus_if.timeout_err_o), 64'h1);
    check("to_id",       64'(bus_if.timeout_id_o), 64'h3);
    tick();
    check("to_next_gnt", 64'(bus_if.grant_o), 64'h1);
    bus_if.mem_opdone_i = 1'b1;
    set_req(0, 2'b00, 32'h0, 32'h0);
    set_req(3, 2'b00, 32'h0, 32'h0);
    tick();
    bus_if.mem_opdone_i = 1'b0;
    check("to_err_sticky", 64'(bus_if.timeout_err_o), 64'h1);

    // Abort versus opdone; illegal op 10 is not a request
    do_reset();
    set_req(1, 2'b10, 32'h0, 32'h0);
    tick();
    check("ab_illegal",  64'(bus_if.grant_o), 64'h0);
    set_req(1, 2'b00, 32'h0, 32'h0);
    set_req(0, 2'b01, 32'h60, 32'h0);
    tick();
    check("ab_grant",    64'(bus_if.grant_o), 64'h1);
    tick();
    set_req(0, 2'b00, 32'h0, 32'h0);
    #1;
    check("ab_no_pulse", 64'(bus_if.req_opdone_o), 64'h0);
    tick();
    check("ab_release",  64'(bus_if.grant_o), 64'h0);
    check("ab_memop",    64'(bus_if.mem_operation_o), 64'h0);
    check("ab_terr",     64'(bus_if.timeout_err_o), 64'h0);
    set_req(0, 2'b01, 32'h64, 32'h0);
    tick();
    check("ab2_grant",   64'(bus_if.grant_o), 64'h1);
    bus_if.mem_opdone_i = 1'b1;
    set_req(0, 2'b00, 32'h0, 32'h0);
    #1;
    check("ab2_pulse",   64'(bus_if.req_opdone_o), 64'h1);
    tick();
    bus_if.mem_opdone_i = 1'b0;
    check("ab2_release", 64'(bus_if.grant_o), 64'h0);
    check("ab2_terr",    64'(bus_if.timeout_err_o), 64'h0);

    // Asynchronous reset in the middle of a grant
    set_req(2, 2'b01, 32'h300, 32'h77);
    tick();
    check("ar_grant",    64'(bus_if.grant_o), 64'h4);
    set_req(0, 2'b01, 32'h100, 32'h0);
    set_req(1, 2'b01, 32'h200, 32'h0);
    #2;
    reset = 1'b1;
    bus_if.mem_opdone_i = 1'b1;
    #1;
    check("ar_grant0",   64'(bus_if.grant_o), 64'h0);
    check("ar_memop0",   64'(bus_if.mem_operation_o), 64'h0);
    check("ar_addr0",    64'(bus_if.mem_addr_o), 64'h0);
    check("ar_opdone0",  64'(bus_if.req_opdone_o), 64'h0);
    #1;
    reset = 1'b0;
    bus_if.mem_opdone_i = 1'b0;
    tick();
    check("ar_first",    64'(bus_if.grant_o), 64'h1);
    check("ar_first_addr", 64'(bus_if.mem_addr_o), 64'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
